// File: rtl/vga_pkg.sv
// VGA timing shared types and default 640x480 timing.
// Default and helper values for vga_timing / vga_lock_gate.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SETTLE,
    RUN
  } state_e;

  function automatic int unsigned h_total(
    input int unsigned act,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp
  );
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(
    input int unsigned act,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp
  );
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_lock_gate.sv
// PLL lock synchronizer, settle delay and run-enable FSM.
// run_o drops as soon as synced lock falls, ahead of the FSM.
module vga_lock_gate
  import vga_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pll_lock_i,
  output logic run_o
);

  localparam int unsigned CW =
    (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic          sync1_q;
  logic          sync2_q;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;

  // Two-flop synchronizer for the asynchronous lock.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_lock_i;
      sync2_q <= sync1_q;
    end
  end

  // Lock/settle/run FSM; the lock-seen edge counts as settle clock one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else if (!sync2_q) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (SETTLE_CYC <= 1) begin
            state_q <= RUN;
            run_q   <= 1'b1;
          end else begin
            state_q <= SETTLE;
            cnt_q   <= CW'(1);
          end
        end
        SETTLE: begin
          if (cnt_q == CW'(SETTLE_CYC - 1)) begin
            state_q <= RUN;
            run_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          run_q <= 1'b1;
        end
        default: begin
          state_q <= WAIT_LOCK;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  assign run_o = run_q & sync2_q;

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator: counters, sync/valid decode, strobes.
// VGA_TIMING_FRAME_CNT_EN adds an 8-bit frame counter port.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter logic        SYNC_POL   = 1'b0,
  parameter int unsigned SETTLE_CYC = 16,
  localparam int unsigned H_TOTAL =
    h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL =
    v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned HW = $clog2(H_TOTAL),
  localparam int unsigned VW = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          pll_lock_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          valid_o,
  output logic [HW-1:0] col_o,
  output logic [VW-1:0] row_o,
  output logic          line_start_o,
  output logic          frame_start_o,
  output logic          running_o
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,output logic [7:0]   frame_cnt_o
`endif
);

  localparam int unsigned HS_LO = H_ACTIVE + H_FP;
  localparam int unsigned HS_HI = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int unsigned VS_LO = V_ACTIVE + V_FP;
  localparam int unsigned VS_HI = V_ACTIVE + V_FP + V_SYNC - 1;

  logic          run;
  logic [HW-1:0] hcnt_d;
  logic [VW-1:0] vcnt_d;
  logic          hs_d;
  logic          vs_d;
  logic          valid_d;
  logic          ls_d;
  logic          fs_d;

  vga_lock_gate #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_gate (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .pll_lock_i(pll_lock_i),
    .run_o     (run)
  );

  // Next pixel position; first RUN cycle and idle both give 0,0.
  always_comb begin
    hcnt_d = '0;
    vcnt_d = '0;
    if (run && running_o) begin
      if (col_o == HW'(H_TOTAL - 1)) begin
        hcnt_d = '0;
        if (row_o == VW'(V_TOTAL - 1)) vcnt_d = '0;
        else vcnt_d = row_o + 1'b1;
      end else begin
        hcnt_d = col_o + 1'b1;
        vcnt_d = row_o;
      end
    end
  end

  // Decode of the next position so outputs register together.
  always_comb begin
    hs_d    = run && hcnt_d >= HW'(HS_LO)
                  && hcnt_d <= HW'(HS_HI);
    vs_d    = run && vcnt_d >= VW'(VS_LO)
                  && vcnt_d <= VW'(VS_HI);
    valid_d = run && hcnt_d < HW'(H_ACTIVE)
                  && vcnt_d < VW'(V_ACTIVE);
    ls_d    = run && hcnt_d == '0;
    fs_d    = run && hcnt_d == '0 && vcnt_d == '0;
  end

  // Registered timing outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hsync_o       <= ~SYNC_POL;
      vsync_o       <= ~SYNC_POL;
      valid_o       <= 1'b0;
      col_o         <= '0;
      row_o         <= '0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      running_o     <= 1'b0;
    end else begin
      hsync_o       <= hs_d ? SYNC_POL : ~SYNC_POL;
      vsync_o       <= vs_d ? SYNC_POL : ~SYNC_POL;
      valid_o       <= valid_d;
      col_o         <= hcnt_d;
      row_o         <= vcnt_d;
      line_start_o  <= ls_d;
      frame_start_o <= fs_d;
      running_o     <= run;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Frame counter: bumps after each frame start, clears when idle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_cnt_o <= 8'd0;
    end else if (!run) begin
      frame_cnt_o <= 8'd0;
    end else if (frame_start_o) begin
      frame_cnt_o <= frame_cnt_o + 8'd1;
    end
  end
`endif

endmodule
